// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between the CDC read side, the BCD converter
// and the 7-segment display manager.
interface bin2bcd_seq_if;
  logic        din_valid;
  logic [15:0] din;
  logic [1:0]  tag_in;
  logic        busy;
  logic        dout_valid;
  logic [19:0] bcd;
  logic [2:0]  ndigits;
  logic [1:0]  tag_out;
  logic        overrun;

  modport master (
    output din_valid, din, tag_in,
    input  busy, dout_valid, bcd, ndigits, tag_out, overrun
  );

  modport slave (
    input  din_valid, din, tag_in,
    output busy, dout_valid, bcd, ndigits, tag_out, overrun
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter.
// The double-dabble engine processes one input bit per cycle. Each result
// carries a significant-digit count for leading-zero blanking and the
// generator-mode tag that arrived with the word.
module bin2bcd_seq (
  input  logic          clock,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [15:0] shreg;
  logic [19:0] scratch;
  logic [19:0] scratch_adj;
  logic [4:0]  bit_cnt;
  logic [1:0]  tag_q;
  logic [2:0]  nd_next;

  logic        busy_r;
  logic        dout_valid_r;
  logic [19:0] bcd_r;
  logic [2:0]  ndigits_r;
  logic [1:0]  tag_out_r;
  logic        overrun_r;

  // Add 3 to every nibble that is 5 or more, all nibbles in parallel
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Significant digits: 1 + index of the highest nonzero nibble, minimum 1
  always_comb begin
    nd_next = 3'd1;
    for (int unsigned i = 1; i < 5; i++) begin
      if (scratch[4*i +: 4] != 4'd0)
        nd_next = 3'(i + 1);
    end
  end

  // Control FSM, conversion datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      scratch      <= '0;
      bit_cnt      <= '0;
      tag_q        <= '0;
      busy_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      bcd_r        <= '0;
      ndigits_r    <= 3'd1;
      tag_out_r    <= '0;
      overrun_r    <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            shreg   <= bus.din;
            tag_q   <= bus.tag_in;
            scratch <= '0;
            bit_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.din_valid)
            overrun_r <= 1'b1;
          scratch <= {scratch_adj[18:0], shreg[15]};
          shreg   <= {shreg[14:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd15)
            state <= DONE;
        end
        DONE: begin
          if (bus.din_valid)
            overrun_r <= 1'b1;
          bcd_r        <= scratch;
          ndigits_r    <= nd_next;
          tag_out_r    <= tag_q;
          dout_valid_r <= 1'b1;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.bcd        = bcd_r;
  assign bus.ndigits    = ndigits_r;
  assign bus.tag_out    = tag_out_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus a random sweep,
// checked against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  bin2bcd_seq_if bus ();

  bin2bcd_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: decimal digits by repeated division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_ndigits(input int unsigned v);
    if (v >= 10000) return 3'd5;
    if (v >= 1000)  return 3'd4;
    if (v >= 100)   return 3'd3;
    if (v >= 10)    return 3'd2;
    return 3'd1;
  endfunction

  task automatic check_reset_values(input string pfx);
    check({pfx, "_bcd"},     32'(bus.bcd),        32'h0);
    check({pfx, "_nd"},      32'(bus.ndigits),    32'd1);
    check({pfx, "_tag"},     32'(bus.tag_out),    32'd0);
    check({pfx, "_busy"},    32'(bus.busy),       32'd0);
    check({pfx, "_overrun"}, 32'(bus.overrun),    32'd0);
    check({pfx, "_dv"},      32'(bus.dout_valid), 32'd0);
  endtask

  // Accept a word at edge k, optionally inject a rejected word at edge k+inject_at,
  // then expect the result exactly after edge k+17.
  task automatic run_word(input logic [15:0] w, input logic [1:0] t,
                          input int inject_at, input logic exp_ovr);
    logic early;
    early = 1'b0;
    bus.din       = w;
    bus.tag_in    = t;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    check("busy_k", 32'(bus.busy), 32'd1);
    check("dv_k", 32'(bus.dout_valid), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == inject_at) begin
        bus.din       = 16'd200;
        bus.tag_in    = 2'b00;
        bus.din_valid = 1'b1;
      end
      tick();
      bus.din_valid = 1'b0;
      if (i == inject_at)
        check("ovr_rise", 32'(bus.overrun), 32'd1);
      if (bus.dout_valid)
        early = 1'b1;
    end
    check("dv_early", 32'(early), 32'd0);
    check("busy_done", 32'(bus.busy), 32'd1);
    tick();
    check("dv_k17", 32'(bus.dout_valid), 32'd1);
    check("bcd", 32'(bus.bcd), 32'(ref_bcd(32'(w))));
    check("ndigits", 32'(bus.ndigits), 32'(ref_ndigits(32'(w))));
    check("tag_out", 32'(bus.tag_out), 32'(t));
    check("busy_after", 32'(bus.busy), 32'd0);
    check("overrun", 32'(bus.overrun), 32'(exp_ovr));
  endtask

  initial begin
    logic        seen;
    logic [15:0] w;
    logic [1:0]  t;
    vectors       = 0;
    miscompares   = 0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.tag_in    = '0;

    // Reset then idle
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("rst");
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.dout_valid) seen = 1'b1;
    end
    check("idle_no_dv", 32'(seen), 32'd0);

    // Single conversion and extremes
    run_word(16'd1234, 2'b10, 0, 1'b0);
    check("bcd_1234", 32'(bus.bcd), 32'h01234);
    tick();
    check("dv_one_cycle", 32'(bus.dout_valid), 32'd0);
    check("bcd_held", 32'(bus.bcd), 32'h01234);
    run_word(16'd0, 2'b00, 0, 1'b0);
    run_word(16'd65535, 2'b01, 0, 1'b0);
    check("bcd_max", 32'(bus.bcd), 32'h65535);
    run_word(16'd9, 2'b10, 0, 1'b0);

    // Random sweep, back to back at 18-cycle spacing
    for (int n = 0; n < 1000; n++) begin
      w = 16'($urandom_range(0, 65535));
      t = 2'($urandom_range(0, 2));
      run_word(w, t, 0, 1'b0);
    end

    // Overrun: rejected word at k+5, then a normal word at k+18
    run_word(16'd100, 2'b01, 5, 1'b1);
    check("ovr_bcd", 32'(bus.bcd), 32'h00100);
    run_word(16'd777, 2'b10, 0, 1'b1);

    // Reset mid-conversion
    bus.din       = 16'd4321;
    bus.tag_in    = 2'b10;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrst");
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.dout_valid) seen = 1'b1;
    end
    check("midrst_no_dv", 32'(seen), 32'd0);
    check("midrst_bcd_kept", 32'(bus.bcd), 32'h0);
    run_word(16'd7, 2'b01, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential 16-bit binary-to-BCD converter between the CDC wrapper's read side (`data_2`/`data_2_valid`) and the 7-segment display manager. Each accepted word is converted with an iterative shift-add-3 (double-dabble) engine, one bit per cycle. The block then presents five packed BCD digits, a significant-digit count for leading-zero blanking, and the generator-mode tag that travelled with the word. It runs on the display-side system clock; `din_valid`/`din`/`tag_in` must already be synchronous to `clock` at integration.

## Interface
- No parameters. Widths are fixed: 16-bit input, 5 BCD digits (20 bits).
- `clock` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state and outputs.
- `din_valid` in 1: one-cycle qualifier for `din`/`tag_in`.
- `din` in 16: unsigned binary word to convert.
- `tag_in` in 2: generator mode for the word (00 none, 01 timer, 10 fibonacci); carried unchanged.
- `busy` out 1: high while a conversion is in progress (SHIFT or DONE).
- `dout_valid` out 1: one-cycle pulse; `bcd`/`ndigits`/`tag_out` updated this cycle.
- `bcd` out 20: digit4..digit0, digit0 at [3:0]; held until the next result.
- `ndigits` out 3: count of significant digits, 1..5 (value 0 gives 1).
- `tag_out` out 2: `tag_in` captured with the converted word.
- `overrun` out 1: sticky; set when `din_valid` arrives while `busy`; cleared only by reset.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: if `din_valid`, latch `din` into the 16-bit shift register, latch `tag_in`, clear the 20-bit scratch register and the 5-bit bit counter, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Every scratch nibble ≥5 gets +3, all nibbles adjusted in parallel.
  - {scratch, shift} is shifted left by 1; the shift register MSB enters scratch bit 0.
  - The counter increments. After the 16th shift, go to DONE.
- DONE, one cycle:
  - `bcd` ← scratch, `tag_out` ← latched tag, `ndigits` ← 1 + index of the highest nonzero nibble (1 if all zero).
  - `dout_valid` pulses. Next state is IDLE.
- Nibble adjust is 4-bit and never overflows. Maximum input 65535 gives 20'h65535, so digit4 ≤ 6.
- `din_valid` in SHIFT or DONE: the word is discarded, `overrun` ← 1, and the conversion in progress is unaffected.
- `din_valid` in IDLE is accepted in the same cycle as a DONE→IDLE transition only if it is sampled while the state is IDLE. The DONE cycle itself counts as busy.
- Reset at any point, including mid-SHIFT:
  - The conversion is aborted with no `dout_valid`.
  - State → IDLE.
  - `bcd`=0, `ndigits`=1, `tag_out`=00, `overrun`=0, `busy`=0, `dout_valid`=0.
- `bcd`/`ndigits`/`tag_out` change only in DONE or on reset. The display manager reads them directly.

## Timing
- Sample `din_valid`=1 in IDLE at edge k. Then:
  - `busy`=1 from edge k.
  - Shifts occur at edges k+1..k+16; state is DONE after edge k+16.
  - Results load and `dout_valid`=1 after edge k+17, with `busy`=0 and state IDLE.
- Latency is 17 cycles from accept to `dout_valid`. Earliest next accept is edge k+18; sustained throughput is 1 word per 18 cycles.
- `dout_valid` is exactly one cycle wide. It is never asserted in consecutive cycles.
- `overrun` rises on the edge that samples the rejected `din_valid`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: hold `reset` 2 cycles → `bcd`=0, `ndigits`=1, `tag_out`=00, `busy`=0, `overrun`=0, no `dout_valid` for 50 cycles.
- Single conversion: `din`=1234, `tag_in`=10, pulse at edge k → `dout_valid` only after edge k+17, `bcd`=20'h01234, `ndigits`=4, `tag_out`=10.
- Extremes: `din`=0 → `bcd`=0, `ndigits`=1. `din`=65535 → `bcd`=20'h65535, `ndigits`=5. `din`=9 → 20'h00009, `ndigits`=1.
- Overrun: accept 100 (`tag_in`=01), pulse `din_valid` with `din`=200 at k+5 → result `bcd`=20'h00100, `tag_out`=01, `overrun`=1 thereafter. A new word at k+18 converts normally and `overrun` stays 1.
- Reset mid-operation: accept 4321, assert `reset` at k+8 → no `dout_valid`, outputs at reset values. A new word 7 afterwards yields 20'h00007 after 17 cycles.
- Random sweep: 1000 random words spaced ≥18 cycles apart → each `bcd` matches the decimal digits of the input, `ndigits` is correct, `overrun` stays 0.
